// File: rtl/pcm_soft_mute.sv
// Stereo PCM soft mute / volume ramp: a shared gain walks one step at a time
// toward the target, and each channel is scaled through a two-stage pipeline.
module pcm_soft_mute #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned GAIN_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mute_req,
    input  logic [7:0]        volume,
    input  logic [3:0]        ramp_rate,
    input  logic              l_data_en,
    input  logic              r_data_en,
    input  logic [DATA_W-1:0] l_data_in,
    input  logic [DATA_W-1:0] r_data_in,
    output logic              l_data_valid,
    output logic              r_data_valid,
    output logic [DATA_W-1:0] l_data_out,
    output logic [DATA_W-1:0] r_data_out,
    output logic              muted,
    output logic              ramping
);

    localparam int unsigned PROD_W = DATA_W + GAIN_W;
    localparam int unsigned CNT_W  = 15;
    localparam int unsigned SHIFT  = 8;

    typedef enum logic [1:0] {
        ST_MUTED     = 2'b00,
        ST_STEADY    = 2'b01,
        ST_RAMP_UP   = 2'b10,
        ST_RAMP_DOWN = 2'b11
    } state_e;

    state_e              state_q, state_d, cur_state_c;
    logic [GAIN_W-1:0]   gain_q, gain_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                muted_q, muted_d;
    logic [GAIN_W-1:0]   target_c;
    logic [CNT_W-1:0]    thr_c;

    logic signed [PROD_W-1:0] gain_ext_c;
    logic signed [PROD_W-1:0] l_prod_c, r_prod_c;
    logic signed [PROD_W-1:0] l_prod_q, r_prod_q;
    logic                     l_vld1_q, r_vld1_q;
    logic                     l_vld2_q, r_vld2_q;
    logic [DATA_W-1:0]        l_out_q, r_out_q;

    function automatic state_e classify(input logic [GAIN_W-1:0] g,
                                        input logic [GAIN_W-1:0] t);
        state_e s;
        if (g < t)
            s = ST_RAMP_UP;
        else if (g > t)
            s = ST_RAMP_DOWN;
        else if (t == '0)
            s = ST_MUTED;
        else
            s = ST_STEADY;
        return s;
    endfunction

    assign target_c = mute_req           ? '0 :
                      (volume == 8'hFF)  ? GAIN_W'(256) :
                                           GAIN_W'(volume);

    assign thr_c = (CNT_W'(1) << ramp_rate) - CNT_W'(1);

    // Gain only moves on a right strobe, so both halves of a pair see the same gain.
    always_comb begin
        gain_d      = gain_q;
        cnt_d       = cnt_q;
        cur_state_c = classify(gain_q, target_c);
        if (cur_state_c == ST_MUTED || cur_state_c == ST_STEADY) begin
            cnt_d = '0;
        end else if (r_data_en) begin
            if (cnt_q >= thr_c) begin
                cnt_d  = '0;
                gain_d = (cur_state_c == ST_RAMP_UP) ? gain_q + GAIN_W'(1)
                                                     : gain_q - GAIN_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        state_d = classify(gain_d, target_c);
        muted_d = (gain_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_MUTED;
            gain_q  <= '0;
            cnt_q   <= '0;
            muted_q <= 1'b1;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            cnt_q   <= cnt_d;
            muted_q <= muted_d;
        end
    end

    // Gain is zero-extended so 256 stays positive; the product always fits.
    assign gain_ext_c = PROD_W'($signed({1'b0, gain_q}));
    assign l_prod_c   = PROD_W'($signed(l_data_in)) * gain_ext_c;
    assign r_prod_c   = PROD_W'($signed(r_data_in)) * gain_ext_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            l_vld1_q <= 1'b0;
            r_vld1_q <= 1'b0;
            l_vld2_q <= 1'b0;
            r_vld2_q <= 1'b0;
            l_prod_q <= '0;
            r_prod_q <= '0;
            l_out_q  <= '0;
            r_out_q  <= '0;
        end else begin
            l_vld1_q <= l_data_en;
            r_vld1_q <= r_data_en;
            l_vld2_q <= l_vld1_q;
            r_vld2_q <= r_vld1_q;
            if (l_data_en)
                l_prod_q <= l_prod_c;
            if (r_data_en)
                r_prod_q <= r_prod_c;
            if (l_vld1_q)
                l_out_q <= DATA_W'(l_prod_q >>> SHIFT);
            if (r_vld1_q)
                r_out_q <= DATA_W'(r_prod_q >>> SHIFT);
        end
    end

    assign l_data_valid = l_vld2_q;
    assign r_data_valid = r_vld2_q;
    assign l_data_out   = l_out_q;
    assign r_data_out   = r_out_q;
    assign muted        = muted_q;
    assign ramping      = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);

endmodule

// File: tb/tb_pcm_soft_mute.sv
// Bench for pcm_soft_mute: per-cycle reference model plus directed table and
// multi-cycle sequences, then randomized traffic.
module tb_pcm_soft_mute;

    localparam int unsigned DATA_W = 24;
    localparam int unsigned GAIN_W = 9;

    logic              clk = 1'b0;
    logic              reset;
    logic              mute_req;
    logic [7:0]        volume;
    logic [3:0]        ramp_rate;
    logic              l_data_en, r_data_en;
    logic [DATA_W-1:0] l_data_in, r_data_in;
    logic              l_data_valid, r_data_valid;
    logic [DATA_W-1:0] l_data_out, r_data_out;
    logic              muted, ramping;

    always #5 clk = ~clk;

    pcm_soft_mute #(.DATA_W(DATA_W), .GAIN_W(GAIN_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .mute_req     (mute_req),
        .volume       (volume),
        .ramp_rate    (ramp_rate),
        .l_data_en    (l_data_en),
        .r_data_en    (r_data_en),
        .l_data_in    (l_data_in),
        .r_data_in    (r_data_in),
        .l_data_valid (l_data_valid),
        .r_data_valid (r_data_valid),
        .l_data_out   (l_data_out),
        .r_data_out   (r_data_out),
        .muted        (muted),
        .ramping      (ramping)
    );

    int n_vec = 0;
    int n_bad = 0;
    int edge_k = 0;

    // Reference model state
    int  m_gain = 0, m_cnt = 0;
    bit  m_muted = 1'b1, m_ramping = 1'b0;
    bit  m_lv = 1'b0, m_rv = 1'b0;
    int  m_lo = 0, m_ro = 0;
    typedef struct { int due; int val; } pend_t;
    pend_t lq[$];
    pend_t rq[$];

    bit        cur_mute = 1'b0;
    logic [7:0] cur_vol = 8'hFF;
    logic [3:0] cur_rate = 4'd0;

    typedef struct {
        logic [7:0] vol;
        int l_in;
        int r_in;
        int exp_l;
        int exp_r;
    } vec_t;
    vec_t tbl[7];

    function automatic int tgt();
        if (cur_mute) return 0;
        if (cur_vol == 8'hFF) return 256;
        return int'(cur_vol);
    endfunction

    function automatic int scale(int x, int g);
        longint p;
        p = longint'(x) * longint'(g);
        return int'(p >>> 8);
    endfunction

    task automatic chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0d, want %0d", name, edge_k, act, exp);
        end
    endtask

    // Effect of one rising edge, from the behavioural rules.
    task automatic model_edge(bit rst, bit len, bit ren, int lin, int rin);
        int t;
        t = tgt();
        edge_k++;
        if (rst) begin
            m_gain = 0; m_cnt = 0;
            lq.delete(); rq.delete();
            m_lo = 0; m_ro = 0; m_lv = 0; m_rv = 0;
            m_muted = 1; m_ramping = 0;
            return;
        end
        if (len) lq.push_back('{edge_k + 1, scale(lin, m_gain)});
        if (ren) rq.push_back('{edge_k + 1, scale(rin, m_gain)});
        if (m_gain == t) begin
            m_cnt = 0;
        end else if (ren) begin
            if (m_cnt >= (1 << cur_rate) - 1) begin
                m_gain = (m_gain < t) ? m_gain + 1 : m_gain - 1;
                m_cnt  = 0;
            end else begin
                m_cnt++;
            end
        end
        m_muted   = (m_gain == 0);
        m_ramping = (m_gain != t);
        m_lv = 0;
        if (lq.size() > 0 && lq[0].due == edge_k) begin
            m_lv = 1; m_lo = lq[0].val; void'(lq.pop_front());
        end
        m_rv = 0;
        if (rq.size() > 0 && rq[0].due == edge_k) begin
            m_rv = 1; m_ro = rq[0].val; void'(rq.pop_front());
        end
    endtask

    task automatic cycle(bit rst, bit len, bit ren, int lin, int rin);
        reset     = rst;
        mute_req  = cur_mute;
        volume    = cur_vol;
        ramp_rate = cur_rate;
        l_data_en = len;
        r_data_en = ren;
        l_data_in = DATA_W'(lin);
        r_data_in = DATA_W'(rin);
        model_edge(rst, len, ren, lin, rin);
        @(negedge clk);
        chk("l_valid", int'(l_data_valid), int'(m_lv));
        chk("r_valid", int'(r_data_valid), int'(m_rv));
        chk("l_out", int'($signed(l_data_out)), m_lo);
        chk("r_out", int'($signed(r_data_out)), m_ro);
        chk("muted", int'(muted), int'(m_muted));
        chk("ramping", int'(ramping), int'(m_ramping));
    endtask

    task automatic pair_seq(int l, int r);
        cycle(0, 1, 0, l, 0);
        cycle(0, 0, 1, 0, r);
    endtask

    task automatic pair_same(int l, int r);
        cycle(0, 1, 1, l, r);
    endtask

    task automatic idle(int n);
        repeat (n) cycle(0, 0, 0, 0, 0);
    endtask

    task automatic settle();
        int guard;
        guard = 0;
        while (m_gain != tgt() && guard < 2000) begin
            pair_same(0, 0);
            guard++;
        end
        if (guard >= 2000) begin
            n_vec++; n_bad++;
            $display("FAIL settle timeout: gain %0d target %0d", m_gain, tgt());
        end
        chk("settle_ramping", int'(ramping), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'hFF, -8388608, 8388607, -8388608, 8388607};
        tbl[1] = '{8'h80, -3, 3, -2, 1};
        tbl[2] = '{8'h80, 1000, -1000, 500, -500};
        tbl[3] = '{8'h40, 7, -7, 1, -2};
        tbl[4] = '{8'h01, -1, 255, -1, 0};
        tbl[5] = '{8'h00, 12345, -1, 0, 0};
        tbl[6] = '{8'hFE, 8388607, -8388608, 8323071, -8323072};

        reset = 1'b1; mute_req = 1'b0; volume = 8'hFF; ramp_rate = 4'd0;
        l_data_en = 1'b0; r_data_en = 1'b0; l_data_in = '0; r_data_in = '0;
        @(negedge clk);

        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        chk("reset_muted", int'(muted), 1);
        chk("reset_l_out", int'($signed(l_data_out)), 0);

        // Startup ramp from 0 to unity, one step per pair
        for (int p = 0; p < 256; p++) begin
            pair_seq(1000, 1000);
            if (p == 254) chk("ramp_still_ramping", int'(ramping), 1);
        end
        chk("ramp_done", int'(ramping), 0);
        idle(2);
        chk("ramp_last_l", int'($signed(l_data_out)), 996);
        chk("ramp_last_r", int'($signed(r_data_out)), 996);
        pair_seq(1000, 1000);
        idle(2);
        chk("unity_l", int'($signed(l_data_out)), 1000);
        chk("unity_r", int'($signed(r_data_out)), 1000);

        // Steady-state scaling table
        for (int i = 0; i < 7; i++) begin
            cur_vol = tbl[i].vol;
            settle();
            pair_same(tbl[i].l_in, tbl[i].r_in);
            idle(1);
            chk("tbl_l_valid", int'(l_data_valid), 1);
            chk("tbl_l_out", int'($signed(l_data_out)), tbl[i].exp_l);
            chk("tbl_r_out", int'($signed(r_data_out)), tbl[i].exp_r);
        end

        // Slow mute from unity: one step every 8 pairs
        cur_vol = 8'hFF;
        settle();
        cur_rate = 4'd3;
        cur_mute = 1'b1;
        for (int p = 0; p < 2048; p++) begin
            cycle(0, 1, 0, 256, 0);
            if (p > 0) chk("mute_pair_gain", int'($signed(r_data_out)), 256 - (p - 1) / 8);
            cycle(0, 0, 1, 0, 256);
            if (p == 2046) chk("muted_early", int'(muted), 0);
            if (p == 2047) chk("muted_end", int'(muted), 1);
        end

        // Direction reversal mid ramp-down, no overshoot at the new target
        cur_rate = 4'd0;
        cur_mute = 1'b0;
        cur_vol  = 8'hFF;
        settle();
        cur_mute = 1'b1;
        repeat (156) pair_same(0, 0);
        cur_mute = 1'b0;
        cur_vol  = 8'hC8;
        pair_same(0, 0);
        pair_same(256, 256);
        idle(1);
        chk("reverse_first_step", int'($signed(l_data_out)), 101);
        chk("reverse_ramping", int'(ramping), 1);
        repeat (110) pair_same(0, 0);
        pair_same(256, -256);
        idle(1);
        chk("reverse_hold_l", int'($signed(l_data_out)), 200);
        chk("reverse_hold_r", int'($signed(r_data_out)), -200);
        chk("reverse_steady", int'(ramping), 0);

        // Reset right after a left strobe drops that sample
        cycle(0, 1, 0, 1000, 0);
        cycle(1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 0, 0);
            chk("rst_no_lvalid", int'(l_data_valid), 0);
        end
        chk("rst_l_out", int'($signed(l_data_out)), 0);
        chk("rst_muted", int'(muted), 1);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic [DATA_W-1:0] la, ra;
            bit rst, le, re;
            if (c % 100 == 0) begin
                int sel;
                sel = $urandom_range(0, 3);
                cur_vol  = (sel == 0) ? 8'hFF : (sel == 1) ? 8'h00 :
                           (sel == 2) ? 8'h80 : 8'($urandom);
                cur_mute = ($urandom_range(0, 3) == 0);
                cur_rate = 4'($urandom_range(0, 2));
            end
            la  = DATA_W'($urandom);
            ra  = DATA_W'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            le  = 1'($urandom);
            re  = 1'($urandom);
            cycle(rst, le, re, int'($signed(la)), int'($signed(ra)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pcm_soft_mute.md
PCM_SOFT_MUTE -- requirements
Module: pcm_soft_mute

Interface
REQ-001 The module SHALL have parameter DATA_W, default 24, meaning the PCM sample width, signed two's complement.
REQ-002 The module SHALL have parameter GAIN_W, default 9, meaning the gain register width; the gain range is 0..256 and 256 is unity.
REQ-003 The module SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port mute_req, input, 1 bit: a level request; 1 ramps the gain to 0.
REQ-006 The module SHALL have port volume, input, 8 bits: the target gain when not muted; 8'hFF maps to 256 and any other value maps to itself.
REQ-007 The module SHALL have port ramp_rate, input, 4 bits: the gain steps by 1 once every 2^ramp_rate stereo pairs.
REQ-008 The module SHALL have port l_data_en, input, 1 bit: a one-cycle strobe marking l_data_in as valid.
REQ-009 The module SHALL have port r_data_en, input, 1 bit: a one-cycle strobe marking r_data_in as valid.
REQ-010 The module SHALL have port l_data_in, input, DATA_W bits: the signed left sample.
REQ-011 The module SHALL have port r_data_in, input, DATA_W bits: the signed right sample.
REQ-012 The module SHALL have port l_data_valid, output, 1 bit: a one-cycle strobe marking l_data_out as valid.
REQ-013 The module SHALL have port r_data_valid, output, 1 bit: a one-cycle strobe marking r_data_out as valid.
REQ-014 The module SHALL have port l_data_out, output, DATA_W bits: the scaled left sample.
REQ-015 The module SHALL have port r_data_out, output, DATA_W bits: the scaled right sample.
REQ-016 The module SHALL have port muted, output, 1 bit: a status flag, 1 when the current gain is 0.
REQ-017 The module SHALL have port ramping, output, 1 bit: a status flag, 1 when the current gain differs from the target.

Function
REQ-018 target SHALL be 0 when mute_req=1; otherwise 256 when volume=8'hFF, else volume; target is evaluated combinationally every cycle.
REQ-019 The left and right channels SHALL be independent parallel datapaths that share one gain register; l_data_en and r_data_en may be asserted in the same cycle.
REQ-020 Each output SHALL be (data_in * gain) arithmetically shifted right by 8, truncated (rounded toward negative infinity), computed in a 33-bit signed intermediate and returned as its low DATA_W bits.
REQ-021 With gain=256 the output SHALL equal the input bit-exactly, including -2^23; with gain=0 the output SHALL be 0.
REQ-022 Latency SHALL be exactly 2 clk cycles: x_data_en at cycle N gives x_data_valid at cycle N+2; the valid strobe is 1 cycle wide, one strobe per input strobe.
REQ-023 x_data_out SHALL hold its value between valid strobes.
REQ-024 Back-to-back input strobes on consecutive cycles SHALL be accepted without loss, since the pipeline is fully pipelined.
REQ-025 The gain applied to a sample SHALL be the gain register value in the cycle of its x_data_en.
REQ-026 The gain SHALL update only in the cycle after an r_data_en, so that L and R of a pair (L first) share one gain.
REQ-027 A pair counter of 15 bits SHALL increment on each r_data_en while gain != target.
REQ-028 When the pair counter equals 2^ramp_rate - 1 and an r_data_en occurs, gain SHALL move 1 toward target and the pair counter SHALL clear.
REQ-029 The pair counter SHALL clear whenever gain == target.
REQ-030 The state machine SHALL have 4 states: MUTED (gain=0 and target=0), RAMP_UP (gain<target), RAMP_DOWN (gain>target), STEADY (gain=target and target!=0).
REQ-031 State SHALL be re-evaluated every cycle from gain and target; a target change mid-ramp reverses direction at the next step without clearing the counter.
REQ-032 Gain SHALL never step past the target, never go below 0 and never exceed 256.
REQ-033 ramp_rate=0 SHALL step the gain on every pair; a ramp_rate change takes effect on the next counter compare.
REQ-034 muted SHALL be 1 exactly when gain=0; ramping SHALL be 1 exactly when gain!=target; both are registered from the post-update gain.

Reset
REQ-035 On reset=1 at a clk edge, gain, the pair counter, the pipeline data and all outputs SHALL clear to 0, and muted SHALL be set to 1.
REQ-036 After reset the state SHALL be MUTED if target=0, otherwise RAMP_UP from gain 0 (pop-free startup).
REQ-037 Reset asserted mid-pipeline SHALL discard in-flight samples: no valid strobe is produced for samples accepted in the 2 cycles before reset.

Verification
REQ-038 Release reset with volume=8'hFF, mute_req=0, ramp_rate=0, then apply 256 pairs of +1000 -> gain reaches 256 after 256 pairs, output ramps 0..996..1000, ramping falls to 0 and the state is STEADY.
REQ-039 In STEADY at gain 256, input L=-8388608 and R=8388607 in the same cycle -> both valid strobes fire 2 cycles later with identical values.
REQ-040 Set gain=128 via volume=8'h80 and input L=-3 -> output -2 (floor), then input +3 -> output +1.
REQ-041 With ramp_rate=3 in STEADY, raise mute_req -> gain drops by 1 every 8 pairs, an L/R pair never sees different gains, and muted=1 once gain is 0.
REQ-042 At gain 100 during RAMP_DOWN, drop mute_req with volume=8'hC8 -> the next step gives gain 101 (RAMP_UP), with no overshoot at 200.
REQ-043 Assert reset one cycle after l_data_en -> no l_data_valid is produced, the outputs read 0 and muted=1.
